// File: rtl/vram_console.sv
// vram_console: byte-stream text console writer for the 60x17 character VRAM.
// Ports: clk/rst_n, in_valid/in_data/in_ready byte input, v_ada/v_cea/v_din VRAM port A, cur_col/cur_row cursor, busy.
module vram_console #(
  parameter int          COLS       = 60,
  parameter int          ROWS       = 17,
  parameter int          ADDR_W     = 10,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] v_ada,
  output logic              v_cea,
  output logic [7:0]        v_din,
  output logic [5:0]        cur_col,
  output logic [4:0]        cur_row,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_CLEAR_ALL,
    S_CLEAR_ROW,
    S_IDLE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ALL = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(COLS-1);
  localparam logic [5:0]        LAST_COL = 6'(COLS-1);
  localparam logic [4:0]        LAST_ROW = 5'(ROWS-1);

  state_t              r_state, w_nx_state;
  logic [5:0]          r_col, w_nx_col;
  logic [4:0]          r_row, w_nx_row;
  logic [ADDR_W-1:0]   r_clr, w_nx_clr;
  logic [ADDR_W-1:0]   r_ada, w_nx_ada;
  logic                r_cea, w_nx_cea;
  logic [7:0]          r_din, w_nx_din;

  logic [ADDR_W-1:0]   w_base;
  logic [ADDR_W-1:0]   w_cur;
  logic [4:0]          w_row_inc;
  logic                w_acc;
  logic                w_print;
  logic                w_lf;
  logic                w_cr;
  logic                w_bs;
  logic                w_ff;

  assign w_base    = ADDR_W'(r_row) * ADDR_W'(COLS);
  assign w_cur     = w_base + ADDR_W'(r_col);
  assign w_row_inc = (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;

  assign in_ready = (r_state == S_IDLE);
  assign busy     = !in_ready;
  assign w_acc    = in_valid && in_ready;

  assign w_print = (in_data >= 8'h20);
  assign w_lf    = (in_data == 8'h0A);
  assign w_cr    = (in_data == 8'h0D);
  assign w_bs    = (in_data == 8'h08);
  assign w_ff    = (in_data == 8'h0C);

  always_comb begin
    w_nx_state = r_state;
    w_nx_col   = r_col;
    w_nx_row   = r_row;
    w_nx_clr   = r_clr;
    w_nx_cea   = 1'b0;
    w_nx_ada   = r_ada;
    w_nx_din   = r_din;
    case (r_state)
      S_CLEAR_ALL: begin
        w_nx_cea = 1'b1;
        w_nx_ada = r_clr;
        w_nx_din = CLEAR_CHAR;
        if (r_clr == LAST_ALL) begin
          w_nx_clr   = '0;
          w_nx_state = S_IDLE;
        end else begin
          w_nx_clr = r_clr + ADDR_W'(1);
        end
      end
      // r_clr counts columns here; cursor row already points at the row
      S_CLEAR_ROW: begin
        w_nx_cea = 1'b1;
        w_nx_ada = w_base + r_clr;
        w_nx_din = CLEAR_CHAR;
        if (r_clr == LAST_CLR) begin
          w_nx_clr   = '0;
          w_nx_state = S_IDLE;
        end else begin
          w_nx_clr = r_clr + ADDR_W'(1);
        end
      end
      default: begin
        if (w_acc) begin
          unique case (1'b1)
            w_print: begin
              w_nx_cea = 1'b1;
              w_nx_ada = w_cur;
              w_nx_din = in_data;
              if (r_col == LAST_COL) begin
                w_nx_col   = '0;
                w_nx_row   = w_row_inc;
                w_nx_clr   = '0;
                w_nx_state = S_CLEAR_ROW;
              end else begin
                w_nx_col = r_col + 6'd1;
              end
            end
            w_lf: begin
              w_nx_col   = '0;
              w_nx_row   = w_row_inc;
              w_nx_clr   = '0;
              w_nx_state = S_CLEAR_ROW;
            end
            w_cr: begin
              w_nx_col = '0;
            end
            w_bs: begin
              if (r_col != 6'd0) begin
                w_nx_col = r_col - 6'd1;
                w_nx_cea = 1'b1;
                w_nx_ada = w_cur - ADDR_W'(1);
                w_nx_din = CLEAR_CHAR;
              end
            end
            w_ff: begin
              w_nx_col   = '0;
              w_nx_row   = '0;
              w_nx_clr   = '0;
              w_nx_state = S_CLEAR_ALL;
            end
            default: begin
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR_ALL;
      r_col   <= '0;
      r_row   <= '0;
      r_clr   <= '0;
      r_cea   <= 1'b0;
      r_ada   <= '0;
      r_din   <= '0;
    end else begin
      r_state <= w_nx_state;
      r_col   <= w_nx_col;
      r_row   <= w_nx_row;
      r_clr   <= w_nx_clr;
      r_cea   <= w_nx_cea;
      r_ada   <= w_nx_ada;
      r_din   <= w_nx_din;
    end
  end

  assign v_ada   = r_ada;
  assign v_cea   = r_cea;
  assign v_din   = r_din;
  assign cur_col = r_col;
  assign cur_row = r_row;

endmodule

// File: tb/tb_vram_console.sv
// tb_vram_console: directed bench with a write scoreboard for vram_console.
// Expected VRAM writes are queued at stimulus time and popped on each v_cea.
module tb_vram_console;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [9:0] v_ada;
  logic       v_cea;
  logic [7:0] v_din;
  logic [5:0] cur_col;
  logic [4:0] cur_row;
  logic       busy;

  int total = 0;
  int bad = 0;
  logic [17:0] q[$];
  int mrow = 0;
  int mcol = 0;
  int nexp = 0;
  int n;
  longint t_prev = 0;
  longint t_last = 0;

  vram_console dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .v_ada    (v_ada),
    .v_cea    (v_cea),
    .v_din    (v_din),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_clr(input int base, input int cnt);
    for (int i = 0; i < cnt; i++)
      q.push_back({10'(base + i), 8'h20});
  endtask

  // Reference cursor model: queues expected writes, returns busy length.
  task automatic model(input logic [7:0] b, output int busy_n);
    busy_n = 0;
    if (b >= 8'h20) begin
      q.push_back({10'(mrow*60 + mcol), b});
      if (mcol == 59) begin
        mcol = 0;
        mrow = (mrow + 1) % 17;
        push_clr(mrow*60, 60);
        busy_n = 60;
      end else begin
        mcol++;
      end
    end else if (b == 8'h0A) begin
      mcol = 0;
      mrow = (mrow + 1) % 17;
      push_clr(mrow*60, 60);
      busy_n = 60;
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        q.push_back({10'(mrow*60 + mcol), 8'h20});
      end
    end else if (b == 8'h0C) begin
      mrow = 0;
      mcol = 0;
      push_clr(0, 1020);
      busy_n = 1020;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int k;
    model(b, nexp);
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (!in_ready && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("accept_wait", {31'd0, in_ready}, 32'd1);
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!in_ready && cnt < 3000) begin
      cnt++;
      @(negedge clk); #1;
    end
  endtask

  task automatic step(input logic [7:0] b, input string tag);
    int w;
    send(b);
    wait_ready(w);
    chk({tag, "_busy"}, w, nexp);
    chk({tag, "_col"}, {26'd0, cur_col}, mcol);
    chk({tag, "_row"}, {27'd0, cur_row}, mrow);
    chk({tag, "_q"}, q.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [17:0] e;
    if (v_cea === 1'b1) begin
      t_prev = t_last;
      t_last = $time;
      if (q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_write got=%0h@%0h exp=none", v_din, v_ada);
      end else begin
        e = q.pop_front();
        chk("wr_addr", {22'd0, v_ada}, {22'd0, e[17:8]});
        chk("wr_data", {24'd0, v_din}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cea", {31'd0, v_cea}, 0);
    chk("rst_ada", {22'd0, v_ada}, 0);
    chk("rst_din", {24'd0, v_din}, 0);
    chk("rst_col", {26'd0, cur_col}, 0);
    chk("rst_row", {27'd0, cur_row}, 0);
    chk("rst_ready", {31'd0, in_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 1);

    push_clr(0, 1020);
    rst_n = 1'b1;
    wait_ready(n);
    chk("init_busy", n, 1020);
    chk("init_q", q.size(), 0);
    chk("init_col", {26'd0, cur_col}, 0);
    chk("init_row", {27'd0, cur_row}, 0);

    send(8'h41);
    send(8'h42);
    @(negedge clk); #1;
    chk("ab_gap", 32'(t_last - t_prev), 10);
    chk("ab_col", {26'd0, cur_col}, 2);
    chk("ab_q", q.size(), 0);

    for (int i = 0; i < 3; i++) step(8'h0A, "lf3");
    for (int i = 0; i < 59; i++) step(8'h61 + 8'(i % 26), "fill");
    step(8'h5A, "wrapZ");

    for (int i = 0; i < 12; i++) step(8'h0A, "lf12");
    for (int i = 0; i < 10; i++) step(8'h30 + 8'(i), "row16");
    step(8'h0A, "lf_wrap");

    step(8'h0A, "lf_a");
    step(8'h0A, "lf_b");
    step(8'h08, "bs_col0");
    repeat (3) @(negedge clk);
    #1;
    chk("bs_col0_nowr", q.size(), 0);
    for (int i = 0; i < 5; i++) step(8'h41 + 8'(i), "row2");
    step(8'h08, "bs");
    step(8'h0D, "cr");
    step(8'h01, "ctl_ign");

    send(8'h0A);
    repeat (10) @(negedge clk);
    #1;
    chk("mid_cea", {31'd0, v_cea}, 1);
    in_valid = 1'b1;
    in_data  = 8'h51;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cea", {31'd0, v_cea}, 0);
    chk("arst_ready", {31'd0, in_ready}, 0);
    chk("arst_busy", {31'd0, busy}, 1);
    chk("arst_row", {27'd0, cur_row}, 0);
    q.delete();
    mrow = 0;
    mcol = 0;
    push_clr(0, 1020);
    model(8'h51, nexp);
    @(negedge clk); #1;
    rst_n = 1'b1;
    wait_ready(n);
    chk("rerst_busy", n, 1020);
    @(negedge clk); #1;
    in_valid = 1'b0;
    chk("rerst_col", {26'd0, cur_col}, mcol);
    chk("rerst_q", q.size(), 0);

    step(8'h0C, "ff");

    repeat (5) @(negedge clk);
    #1;
    chk("final_q", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
